dcache_stream_responder: RTL and testbench

Cache-side responder for the hardware speed-module request interface. Accepts one stream request (base address, depth in cache lines) from the speed-module requester, injects one aligned line access per line into dcache_tag_stage through a spare issue slot, re-issues accesses that miss, and reports per-line hits and overall completion back to the requester. It sits beside dcache_tag_stage and dcache_data_stage and produces the `dcache_response` and `dcache_complete` pulses that the requester consumes.

---
 rtl/dcache_stream_responder_pkg.sv | 24 ++
 rtl/dcache_stream_responder_sync_fifo.sv | 67 ++++++
 rtl/dcache_stream_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_dcache_stream_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_stream_responder_pkg.sv
// Shared types and constants for the dcache stream responder.
// Holds the cache-line geometry, the scalar address type and the FSM state enum.
package dcache_stream_responder_pkg;

  typedef logic [31:0] scalar_t;

  localparam int unsigned CACHE_LINE_BYTES = 64;
  localparam int unsigned LINE_SHIFT       = $clog2(CACHE_LINE_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } stream_resp_state_t;

  function automatic scalar_t line_align(input scalar_t addr);
    return addr & ~scalar_t'(CACHE_LINE_BYTES - 1);
  endfunction

  function automatic scalar_t line_offset(input scalar_t lines);
    return lines << LINE_SHIFT;
  endfunction

endpackage

// File: rtl/dcache_stream_responder_sync_fifo.sv
// Small synchronous FIFO used as the retry queue of the stream responder.
// Power-of-two SIZE; flush_i empties it; a push into a full FIFO is dropped unless a pop frees a slot.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(SIZE);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [SIZE];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_s, push_ok_s, pop_ok_s;

  assign full_s     = (count_q == CNT_W'(SIZE));
  assign empty_o    = (count_q == CNT_W'(0));
  assign pop_ok_s   = pop_i && !empty_o;
  assign push_ok_s  = push_i && (!full_s || pop_ok_s);
  assign pop_data_o = mem_q[rd_q];

  // Pointer and occupancy next-state
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      wr_d    = wr_q + PTR_W'(push_ok_s);
      rd_d    = rd_q + PTR_W'(pop_ok_s);
      count_d = count_q + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (push_ok_s && !flush_i) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/dcache_stream_responder.sv
// Streams line-aligned accesses into dcache_tag_stage, retries misses and reports hits/completion.
// Optional DCACHE_STREAM_PERF_EN adds perf_miss_count and perf_stall_cycles outputs.
module dcache_stream_responder
  import dcache_stream_responder_pkg::*;
#(
  parameter int MAX_IN_FLIGHT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        interface_req,
  input  logic [31:0] base_addr,
  input  logic [31:0] depth,
  output logic        interface_busy,
  output logic        tag_inject_req,
  output logic [31:0] tag_inject_addr,
  input  logic        tag_inject_ack,
  input  logic        dd_inject_valid,
  input  logic        dd_inject_hit,
  input  logic [31:0] dd_inject_addr,
  output logic        dcache_response,
  output logic        dcache_complete
`ifdef DCACHE_STREAM_PERF_EN
  ,
  output logic [31:0] perf_miss_count,
  output logic [31:0] perf_stall_cycles
`endif
);

  localparam int IFW = $clog2(MAX_IN_FLIGHT) + 1;

  stream_resp_state_t state_q, state_d;
  scalar_t            base_q, base_d, depth_q, depth_d;
  scalar_t            issued_q, issued_d, hits_q, hits_d;
  scalar_t            addr_q, addr_d;
  logic [IFW-1:0]     in_flight_q, in_flight_d, unresolved_q, unresolved_d;
  logic               req_q, req_d, retry_q, retry_d;
  logic               resp_q, resp_d, complete_q, complete_d, busy_q, busy_d;

  logic               accept_s, ack_s, prim_acc_s, resolve_s, hit_s, miss_s, all_hit_s, slot_free_s;
  scalar_t            issued_nx_s, hits_nx_s;
  logic [IFW-1:0]     in_flight_nx_s, unresolved_nx_s;
  logic               fifo_pop_s, fifo_empty_s;
  scalar_t            fifo_head_s;

  assign accept_s    = (state_q == ST_IDLE) && interface_req;
  assign ack_s       = req_q && tag_inject_ack;
  assign prim_acc_s  = ack_s && !retry_q;
  // Resolutions with nothing outstanding are stale (e.g. left over from before a reset)
  assign resolve_s   = (state_q == ST_ACTIVE) && dd_inject_valid && (unresolved_q != IFW'(0));
  assign hit_s       = resolve_s && dd_inject_hit;
  assign miss_s      = resolve_s && !dd_inject_hit;
  assign slot_free_s = !req_q || ack_s;

  assign issued_nx_s     = issued_q + 32'(prim_acc_s);
  assign hits_nx_s       = hits_q + 32'(hit_s);
  assign in_flight_nx_s  = in_flight_q + IFW'(prim_acc_s) - IFW'(hit_s);
  assign unresolved_nx_s = unresolved_q + IFW'(ack_s) - IFW'(resolve_s);
  assign all_hit_s       = (state_q == ST_ACTIVE) && (hits_nx_s == depth_q);

  sync_fifo #(
    .WIDTH ($bits(scalar_t)),
    .SIZE  (MAX_IN_FLIGHT)
  ) u_retry_fifo (
    .clk_i       (clk),
    .reset_i     (reset),
    .flush_i     (accept_s),
    .push_i      (miss_s),
    .push_data_i (dd_inject_addr),
    .pop_i       (fifo_pop_s),
    .pop_data_o  (fifo_head_s),
    .empty_o     (fifo_empty_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = (depth == 32'd0) ? ST_DONE : ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (all_hit_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath next values
  always_comb begin
    base_d       = base_q;
    depth_d      = depth_q;
    issued_d     = issued_q;
    hits_d       = hits_q;
    in_flight_d  = in_flight_q;
    unresolved_d = unresolved_q;
    req_d        = req_q;
    addr_d       = addr_q;
    retry_d      = retry_q;
    fifo_pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_d = 1'b0;
        if (accept_s) begin
          base_d       = line_align(base_addr);
          depth_d      = depth;
          issued_d     = '0;
          hits_d       = '0;
          in_flight_d  = '0;
          unresolved_d = '0;
          retry_d      = 1'b0;
          addr_d       = line_align(base_addr);
          req_d        = (depth != 32'd0);
        end else begin
          retry_d = 1'b0;
        end
      end
      ST_ACTIVE: begin
        issued_d     = issued_nx_s;
        hits_d       = hits_nx_s;
        in_flight_d  = in_flight_nx_s;
        unresolved_d = unresolved_nx_s;
        if (all_hit_s) begin
          req_d = 1'b0;
        end else if (slot_free_s) begin
          // Retries win over new lines; the popped entry stays counted in in_flight
          if (!fifo_empty_s) begin
            fifo_pop_s = 1'b1;
            req_d      = 1'b1;
            addr_d     = fifo_head_s;
            retry_d    = 1'b1;
          end else if ((issued_nx_s < depth_q) && (in_flight_nx_s < IFW'(MAX_IN_FLIGHT))) begin
            req_d   = 1'b1;
            addr_d  = base_q + line_offset(issued_nx_s);
            retry_d = 1'b0;
          end else begin
            req_d = 1'b0;
          end
        end else begin
          req_d = 1'b1;
        end
      end
      ST_DONE: req_d = 1'b0;
      default: req_d = 1'b0;
    endcase
    resp_d     = hit_s;
    complete_d = all_hit_s || ((state_q == ST_DONE) && !complete_q);
    busy_d     = (state_d != ST_IDLE) || complete_d;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q       <= '0;
      depth_q      <= '0;
      issued_q     <= '0;
      hits_q       <= '0;
      in_flight_q  <= '0;
      unresolved_q <= '0;
      req_q        <= 1'b0;
      addr_q       <= '0;
      retry_q      <= 1'b0;
      resp_q       <= 1'b0;
      complete_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      base_q       <= base_d;
      depth_q      <= depth_d;
      issued_q     <= issued_d;
      hits_q       <= hits_d;
      in_flight_q  <= in_flight_d;
      unresolved_q <= unresolved_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      retry_q      <= retry_d;
      resp_q       <= resp_d;
      complete_q   <= complete_d;
      busy_q       <= busy_d;
    end
  end

  assign interface_busy  = busy_q;
  assign tag_inject_req  = req_q;
  assign tag_inject_addr = addr_q;
  assign dcache_response = resp_q;
  assign dcache_complete = complete_q;

`ifdef DCACHE_STREAM_PERF_EN
  logic [31:0] perf_miss_q, perf_stall_q;

  // Saturating miss and tag-stall counters, cleared per accepted request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_miss_q  <= '0;
      perf_stall_q <= '0;
    end else if (accept_s) begin
      perf_miss_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (miss_s && (perf_miss_q != 32'hFFFF_FFFF)) begin
        perf_miss_q <= perf_miss_q + 32'd1;
      end
      if ((state_q == ST_ACTIVE) && req_q && !tag_inject_ack && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_miss_count   = perf_miss_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_dcache_stream_responder.sv
// Scoreboard bench for dcache_stream_responder: stimulus pushes expected issue addresses,
// a negedge monitor models the tag/data stages and checks issues, responses, completion and busy.
module tb_dcache_stream_responder;
  import dcache_stream_responder_pkg::*;

  localparam int MAXF = 4;

  logic        clk = 1'b0;
  logic        reset, interface_req, tag_inject_ack;
  logic        dd_inject_valid, dd_inject_hit;
  logic [31:0] base_addr, depth, dd_inject_addr;
  logic        interface_busy, tag_inject_req, dcache_response, dcache_complete;
  logic [31:0] tag_inject_addr;
`ifdef DCACHE_STREAM_PERF_EN
  logic [31:0] perf_miss_count, perf_stall_cycles;
`endif

  dcache_stream_responder #(.MAX_IN_FLIGHT(MAXF)) dut (
    .clk             (clk),
    .reset           (reset),
    .interface_req   (interface_req),
    .base_addr       (base_addr),
    .depth           (depth),
    .interface_busy  (interface_busy),
    .tag_inject_req  (tag_inject_req),
    .tag_inject_addr (tag_inject_addr),
    .tag_inject_ack  (tag_inject_ack),
    .dd_inject_valid (dd_inject_valid),
    .dd_inject_hit   (dd_inject_hit),
    .dd_inject_addr  (dd_inject_addr),
    .dcache_response (dcache_response),
    .dcache_complete (dcache_complete)
`ifdef DCACHE_STREAM_PERF_EN
    ,
    .perf_miss_count   (perf_miss_count),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int      checks = 0, errors = 0, cyc = 0;
  scalar_t exp_addr_q[$];
  scalar_t pend_addr_q[$];
  int      pend_due_q[$];
  int      resp_delay = 2, ack_low_until = 0;
  scalar_t miss_addr = '0;
  bit      miss_armed = 1'b0, stale_req = 1'b0;
  int      cur_depth = 0, hits_driven = 0, resp_seen = 0, cmpl_seen = 0, acc_count = 0;
  int      exp_cmpl_cyc = -1, exp_resp_cyc = -1, exp_first_cyc = -1, busy_on_cyc = -1;
  bit      busy_model = 1'b0, prev_stall = 1'b0;
  scalar_t prev_addr = '0, mon_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Monitor plus tag/data stage model
  initial begin
    tag_inject_ack  = 1'b1;
    dd_inject_valid = 1'b0;
    dd_inject_hit   = 1'b0;
    dd_inject_addr  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        exp_addr_q.delete();
        pend_addr_q.delete();
        pend_due_q.delete();
        busy_model = 1'b0;  busy_on_cyc = -1;  exp_cmpl_cyc = -1;
        exp_resp_cyc = -1;  exp_first_cyc = -1; prev_stall = 1'b0; miss_armed = 1'b0;
        dd_inject_valid = 1'b0;
        dd_inject_hit   = 1'b0;
      end else begin
        if (dcache_response || (cyc == exp_resp_cyc)) begin
          check("response_pulse", 32'(dcache_response), (cyc == exp_resp_cyc) ? 32'd1 : 32'd0);
          if (dcache_response) resp_seen++;
        end
        if (dcache_complete || (cyc == exp_cmpl_cyc)) begin
          check("complete_pulse", 32'(dcache_complete), (cyc == exp_cmpl_cyc) ? 32'd1 : 32'd0);
          if (dcache_complete) cmpl_seen++;
        end
        if (cyc == busy_on_cyc) busy_model = 1'b1;
        check("busy", 32'(interface_busy), 32'(busy_model));
        if (cyc == exp_cmpl_cyc) busy_model = 1'b0;
        if (cyc == exp_first_cyc) check("first_req_latency", 32'(tag_inject_req), 32'd1);
        if (prev_stall) begin
          check("hold_req", 32'(tag_inject_req), 32'd1);
          check("hold_addr", tag_inject_addr, prev_addr);
        end
        tag_inject_ack = (cyc >= ack_low_until);
        if (tag_inject_req && tag_inject_ack) begin
          acc_count++;
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue actual=%h required=none", tag_inject_addr);
          end else begin
            check("issue_addr", tag_inject_addr, exp_addr_q.pop_front());
          end
          check("in_flight_limit", 32'(pend_addr_q.size() < MAXF), 32'd1);
          pend_addr_q.push_back(tag_inject_addr);
          pend_due_q.push_back(cyc + resp_delay);
        end
        prev_stall = tag_inject_req && !tag_inject_ack;
        prev_addr  = tag_inject_addr;
        dd_inject_valid = 1'b0;
        dd_inject_hit   = 1'b0;
        if (stale_req) begin
          stale_req       = 1'b0;
          dd_inject_valid = 1'b1;
          dd_inject_hit   = 1'b1;
          dd_inject_addr  = 32'h0000_5000;
        end else if ((pend_due_q.size() != 0) && (pend_due_q[0] <= cyc)) begin
          void'(pend_due_q.pop_front());
          mon_a           = pend_addr_q.pop_front();
          dd_inject_valid = 1'b1;
          dd_inject_addr  = mon_a;
          if (miss_armed && (mon_a == miss_addr)) begin
            miss_armed = 1'b0;
          end else begin
            dd_inject_hit = 1'b1;
            hits_driven++;
            exp_resp_cyc = cyc + 1;
            if (hits_driven == cur_depth) exp_cmpl_cyc = cyc + 1;
          end
        end
      end
    end
  end

  task automatic run_stream(input scalar_t b, input scalar_t d, input int delay,
                            input int ack_low, input int exp_resp_cnt);
    int r0, c0, n;
    r0 = resp_seen;
    c0 = cmpl_seen;
    resp_delay    = delay;
    hits_driven   = 0;
    cur_depth     = int'(d);
    base_addr     = b;
    depth         = d;
    interface_req = 1'b1;
    busy_on_cyc   = cyc + 2;
    ack_low_until = cyc + 2 + ack_low;
    exp_first_cyc = (d != 32'd0) ? cyc + 2 : -1;
    if (d == 32'd0) exp_cmpl_cyc = cyc + 3;
    step();
    interface_req = 1'b0;
    n = 0;
    while ((cmpl_seen == c0) && (n < 400)) begin
      step();
      n++;
    end
    if (cmpl_seen == c0) begin
      checks++;
      errors++;
      $display("FAIL complete_timeout actual=none required=pulse base=%h", b);
    end
    step();
    step();
    check("response_count", 32'(resp_seen - r0), 32'(exp_resp_cnt));
    check("issue_queue_drained", 32'(exp_addr_q.size()), 32'd0);
  endtask

  // Directed stimulus
  initial begin
    int n, r0, a0;
    reset = 1'b1;
    interface_req = 1'b0;
    base_addr = '0;
    depth = '0;
    step();
    step();
    check("rst_req", 32'(tag_inject_req), 32'd0);
    check("rst_addr", tag_inject_addr, 32'd0);
    check("rst_resp", 32'(dcache_response), 32'd0);
    check("rst_complete", 32'(dcache_complete), 32'd0);
    check("rst_busy", 32'(interface_busy), 32'd0);
    reset = 1'b0;
    step();

    exp_addr_q = '{32'h0000_1000, 32'h0000_1040, 32'h0000_1080};
    run_stream(32'h0000_1010, 32'd3, 2, 0, 3);

    run_stream(32'h0000_8000, 32'd0, 2, 0, 0);

    exp_addr_q = '{32'h0000_4000, 32'h0000_4040, 32'h0000_4080,
                   32'h0000_40C0, 32'h0000_4100, 32'h0000_4140};
    run_stream(32'h0000_4000, 32'd6, 4, 5, 6);
`ifdef DCACHE_STREAM_PERF_EN
    check("perf_stall_cycles", perf_stall_cycles, 32'd5);
`endif

    miss_addr  = 32'h0000_2000;
    miss_armed = 1'b1;
    exp_addr_q = '{32'h0000_2000, 32'h0000_2040, 32'h0000_2000};
    run_stream(32'h0000_2000, 32'd2, 1, 0, 2);
`ifdef DCACHE_STREAM_PERF_EN
    check("perf_miss_count", perf_miss_count, 32'd1);
`endif

    exp_addr_q = '{32'hFFFF_FFC0, 32'h0000_0000};
    run_stream(32'hFFFF_FFC0, 32'd2, 2, 0, 2);

    // Reset after two of five lines have been issued
    exp_addr_q = '{32'h0000_6000, 32'h0000_6040, 32'h0000_6080, 32'h0000_60C0, 32'h0000_6100};
    resp_delay = 50;
    hits_driven = 0;
    cur_depth = 5;
    base_addr = 32'h0000_6000;
    depth = 32'd5;
    interface_req = 1'b1;
    busy_on_cyc = cyc + 2;
    ack_low_until = 0;
    exp_first_cyc = cyc + 2;
    step();
    interface_req = 1'b0;
    a0 = acc_count;
    n = 0;
    while (((acc_count - a0) < 2) && (n < 50)) begin
      step();
      n++;
    end
    check("two_issued_before_reset", 32'(acc_count - a0), 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("mid_rst_req", 32'(tag_inject_req), 32'd0);
    check("mid_rst_addr", tag_inject_addr, 32'd0);
    check("mid_rst_resp", 32'(dcache_response), 32'd0);
    check("mid_rst_complete", 32'(dcache_complete), 32'd0);
    check("mid_rst_busy", 32'(interface_busy), 32'd0);
    r0 = resp_seen;
    stale_req = 1'b1;
    repeat (4) step();
    check("stale_no_response", 32'(resp_seen - r0), 32'd0);
`ifdef DCACHE_STREAM_PERF_EN
    check("perf_miss_after_rst", perf_miss_count, 32'd0);
    check("perf_stall_after_rst", perf_stall_cycles, 32'd0);
`endif
    exp_addr_q = '{32'h0000_7000};
    run_stream(32'h0000_7000, 32'd1, 2, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
